// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    localparam int MASK_W = 8;
    localparam int INST_W = 32;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational grant select between IFU and LSU
//   ifu_valid, lsu_valid : requester valids
//   last_owner           : requester served last (only with MEM_ARB_RR_EN)
//   grant                : selected requester
//   MEM_ARB_RR_EN        : round-robin on contention; otherwise LSU > IFU
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   ifu_valid,
    input  logic   lsu_valid,
`ifdef MEM_ARB_RR_EN
    input  owner_t last_owner,
`endif
    output owner_t grant
);

    always_comb begin
        grant = OWN_IFU;
`ifdef MEM_ARB_RR_EN
        // On contention hand the port to whoever was not served last.
        if (ifu_valid && lsu_valid) begin
            grant = (last_owner == OWN_LSU) ? OWN_IFU : OWN_LSU;
        end else if (lsu_valid) begin
            grant = OWN_LSU;
        end
`else
        if (lsu_valid) begin
            grant = OWN_LSU;
        end
`endif
        // ifu_valid only matters for contention; a lone IFU falls to the default.
        if (!ifu_valid && !lsu_valid) begin
            grant = OWN_IFU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between IFU and LSU, one transaction in flight
//   clk, rst                 : clock, synchronous active-high reset
//   ifu_req_* / ifu_resp_*   : fetch request (addr) and 32-bit instruction return
//   lsu_req_* / lsu_resp_*   : load/store request (addr, wen, wdata, wmask) and data return
//   mem_req_* / mem_resp_*   : downstream request (held until ready) and one-beat response
//   busy                     : a transaction is in progress
//   bus_err                  : one-cycle pulse when the response timer expires
//   MEM_ARB_RR_EN            : round-robin grant instead of fixed LSU priority
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int RESP_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_req_addr,
    output logic              ifu_resp_valid,
    output logic [INST_W-1:0] ifu_resp_inst,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_req_addr,
    input  logic              lsu_req_wen,
    input  logic [DATA_W-1:0] lsu_req_wdata,
    input  logic [MASK_W-1:0] lsu_req_wmask,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_resp_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_wen,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [MASK_W-1:0] mem_req_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata,
    output logic              busy,
    output logic              bus_err
);

    localparam int TMR_W = $clog2(RESP_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(RESP_TIMEOUT);

    state_t           state;
    owner_t           owner;
    owner_t           grant;
    logic [TMR_W-1:0] timer;
    logic             idle;
`ifdef MEM_ARB_RR_EN
    owner_t           last_owner;
`endif

    mem_arb_pick u_pick (
        .ifu_valid  (ifu_req_valid),
        .lsu_valid  (lsu_req_valid),
`ifdef MEM_ARB_RR_EN
        .last_owner (last_owner),
`endif
        .grant      (grant)
    );

    // Ready is held low while rst is asserted so nothing is offered during reset.
    assign idle          = (state == IDLE) && !rst;
    assign ifu_req_ready = idle && ifu_req_valid && (grant == OWN_IFU);
    assign lsu_req_ready = idle && lsu_req_valid && (grant == OWN_LSU);
    assign busy          = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            owner          <= OWN_IFU;
            timer          <= '0;
            mem_req_valid  <= 1'b0;
            mem_req_addr   <= '0;
            mem_req_wen    <= 1'b0;
            mem_req_wdata  <= '0;
            mem_req_wmask  <= '0;
            ifu_resp_valid <= 1'b0;
            ifu_resp_inst  <= '0;
            lsu_resp_valid <= 1'b0;
            lsu_resp_rdata <= '0;
            bus_err        <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_owner     <= OWN_IFU;
`endif
        end else begin
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;
            bus_err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (lsu_req_ready || ifu_req_ready) begin
                        state         <= ISSUE;
                        mem_req_valid <= 1'b1;
                        timer         <= '0;
                        owner         <= grant;
`ifdef MEM_ARB_RR_EN
                        last_owner    <= grant;
`endif
                        if (lsu_req_ready) begin
                            mem_req_addr  <= lsu_req_addr;
                            mem_req_wen   <= lsu_req_wen;
                            mem_req_wdata <= lsu_req_wdata;
                            mem_req_wmask <= lsu_req_wmask;
                        end else begin
                            mem_req_addr  <= ifu_req_addr;
                            mem_req_wen   <= 1'b0;
                            mem_req_wdata <= '0;
                            mem_req_wmask <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (timer == TMR_MAX) begin
                        state         <= IDLE;
                        mem_req_valid <= 1'b0;
                        bus_err       <= 1'b1;
                        if (owner == OWN_LSU) begin
                            lsu_resp_valid <= 1'b1;
                            lsu_resp_rdata <= '0;
                        end else begin
                            ifu_resp_valid <= 1'b1;
                            ifu_resp_inst  <= '0;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                        if (mem_req_ready) begin
                            state         <= WAIT;
                            mem_req_valid <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    // A beat arriving on the last allowed cycle still wins over the abort.
                    if (mem_resp_valid) begin
                        state <= IDLE;
                        if (owner == OWN_LSU) begin
                            lsu_resp_valid <= 1'b1;
                            lsu_resp_rdata <= mem_req_wen ? '0 : mem_resp_rdata;
                        end else begin
                            ifu_resp_valid <= 1'b1;
                            ifu_resp_inst  <= mem_req_addr[2] ? mem_resp_rdata[INST_W +: INST_W]
                                                              : mem_resp_rdata[0 +: INST_W];
                        end
                    end else if (timer == TMR_MAX) begin
                        state   <= IDLE;
                        bus_err <= 1'b1;
                        if (owner == OWN_LSU) begin
                            lsu_resp_valid <= 1'b1;
                            lsu_resp_rdata <= '0;
                        end else begin
                            ifu_resp_valid <= 1'b1;
                            ifu_resp_inst  <= '0;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    mem_req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter (table, random and corner sequences)
module tb_mem_arbiter;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready;
    logic [63:0] ifu_req_addr;
    logic        ifu_resp_valid;
    logic [31:0] ifu_resp_inst;
    logic        lsu_req_valid, lsu_req_ready;
    logic [63:0] lsu_req_addr;
    logic        lsu_req_wen;
    logic [63:0] lsu_req_wdata;
    logic [7:0]  lsu_req_wmask;
    logic        lsu_resp_valid;
    logic [63:0] lsu_resp_rdata;
    logic        mem_req_valid, mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_req_wen;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;
    logic        busy, bus_err;

    int total = 0;
    int bad   = 0;
`ifdef MEM_ARB_RR_EN
    bit m_last_lsu = 1'b0;
`endif

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(64), .DATA_W(64), .RESP_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_inst(ifu_resp_inst),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_rdata(lsu_resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .busy(busy), .bus_err(bus_err)
    );

    typedef struct {
        bit          iv;
        bit          lv;
        logic [63:0] ia;
        logic [63:0] la;
        bit          wen;
        logic [63:0] wd;
        logic [7:0]  wm;
        int          rdy;       // cycles mem_req_ready stays low in ISSUE
        int          rsp;       // response cycles after the ready cycle, <=0 means none
        logic [63:0] rdata;
        bit          exp_lsu;
        logic [63:0] exp_data;
        bit          exp_err;
        int          exp_pulse; // cycle of owner resp_valid, ISSUE entry = cycle 1
    } vec_t;

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference outcome from the rules: who wins, when the owner hears back, with what.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        bit   ok;
        r = v;
`ifdef MEM_ARB_RR_EN
        r.exp_lsu = (v.iv && v.lv) ? !m_last_lsu : v.lv;
`else
        r.exp_lsu = v.lv;
`endif
        ok = (v.rsp > 0) && (v.rdy + 1 + v.rsp <= T + 1);
        r.exp_err   = !ok;
        r.exp_pulse = ok ? v.rdy + v.rsp + 2 : T + 2;
        if (!ok)
            r.exp_data = 64'd0;
        else if (r.exp_lsu)
            r.exp_data = v.wen ? 64'd0 : v.rdata;
        else
            r.exp_data = v.ia[2] ? (v.rdata >> 32) : (v.rdata & 64'hFFFF_FFFF);
        return r;
    endfunction

    // Entered between edges with the previous cycle's outputs already checked.
    task automatic txn(input vec_t v);
        bit issue, resp_cyc;
        ifu_req_valid  = v.iv;
        ifu_req_addr   = v.ia;
        lsu_req_valid  = v.lv;
        lsu_req_addr   = v.la;
        lsu_req_wen    = v.wen;
        lsu_req_wdata  = v.wd;
        lsu_req_wmask  = v.wm;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        #1;
        chk1("ifu_ready_accept", ifu_req_ready, !v.exp_lsu);
        chk1("lsu_ready_accept", lsu_req_ready, v.exp_lsu);
        chk1("busy_accept", busy, 1'b0);
        @(posedge clk);
        #1;
        for (int c = 1; c <= v.exp_pulse; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            issue    = (c <= v.rdy + 1) && (c < v.exp_pulse);
            resp_cyc = (v.rsp > 0) && (c == v.rdy + 1 + v.rsp);
            ifu_req_valid  = (c < v.exp_pulse) ? 1'($urandom_range(0, 1)) : 1'b0;
            lsu_req_valid  = (c < v.exp_pulse) ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_req_ready  = (c > v.rdy);
            mem_resp_valid = resp_cyc ? 1'b1 :
                             ((issue || c == v.exp_pulse) ? 1'($urandom_range(0, 1)) : 1'b0);
            mem_resp_rdata = resp_cyc ? v.rdata : {$urandom, $urandom};
            @(negedge clk);
            chk1("mem_req_valid", mem_req_valid, issue);
            chk1("busy", busy, c < v.exp_pulse);
            chk1("ifu_resp_valid", ifu_resp_valid, (c == v.exp_pulse) && !v.exp_lsu);
            chk1("lsu_resp_valid", lsu_resp_valid, (c == v.exp_pulse) && v.exp_lsu);
            chk1("bus_err", bus_err, (c == v.exp_pulse) && v.exp_err);
            if (c < v.exp_pulse) begin
                chk1("ifu_ready_busy", ifu_req_ready, 1'b0);
                chk1("lsu_ready_busy", lsu_req_ready, 1'b0);
            end
            if (issue) begin
                chk64("mem_req_addr", mem_req_addr, v.exp_lsu ? v.la : v.ia);
                chk1("mem_req_wen", mem_req_wen, v.exp_lsu && v.wen);
                if (v.exp_lsu) begin
                    chk64("mem_req_wdata", mem_req_wdata, v.wd);
                    chk64("mem_req_wmask", 64'(mem_req_wmask), 64'(v.wm));
                end
            end
            if (c == v.exp_pulse) begin
                if (v.exp_lsu)
                    chk64("lsu_resp_rdata", lsu_resp_rdata, v.exp_data);
                else
                    chk64("ifu_resp_inst", 64'(ifu_resp_inst), v.exp_data & 64'hFFFF_FFFF);
            end
        end
`ifdef MEM_ARB_RR_EN
        m_last_lsu = v.exp_lsu;
`endif
    endtask

    task automatic idle_cycles(input int n);
        ifu_req_valid  = 1'b0;
        lsu_req_valid  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b0;
        repeat (n) begin
            @(negedge clk);
            chk1("busy_idle", busy, 1'b0);
        end
    endtask

    vec_t tbl[10];
    vec_t v;
    int   r;

    initial begin
        tbl[0] = '{iv:1, lv:0, ia:64'h8000_0004, la:64'h0, wen:0, wd:64'h0, wm:8'h0, rdy:0, rsp:2,
                   rdata:64'h1111_2222_3333_4444, exp_lsu:0, exp_data:64'h1111_2222, exp_err:0, exp_pulse:4};
        tbl[1] = '{iv:1, lv:1, ia:64'h8000_0010, la:64'h1000, wen:0, wd:64'h0, wm:8'h0, rdy:0, rsp:1,
                   rdata:64'hAAAA_BBBB_CCCC_DDDD, exp_lsu:1, exp_data:64'hAAAA_BBBB_CCCC_DDDD, exp_err:0, exp_pulse:3};
`ifdef MEM_ARB_RR_EN
        tbl[2] = '{iv:1, lv:1, ia:64'h8000_0014, la:64'h2000, wen:0, wd:64'h0, wm:8'h0, rdy:1, rsp:1,
                   rdata:64'h0123_4567_89AB_CDEF, exp_lsu:0, exp_data:64'h0123_4567, exp_err:0, exp_pulse:4};
`else
        tbl[2] = '{iv:1, lv:1, ia:64'h8000_0014, la:64'h2000, wen:0, wd:64'h0, wm:8'h0, rdy:1, rsp:1,
                   rdata:64'h0123_4567_89AB_CDEF, exp_lsu:1, exp_data:64'h0123_4567_89AB_CDEF, exp_err:0, exp_pulse:4};
`endif
        tbl[3] = '{iv:1, lv:1, ia:64'h8000_0018, la:64'h2008, wen:1, wd:64'h5555, wm:8'hFF, rdy:0, rsp:1,
                   rdata:64'h7777, exp_lsu:1, exp_data:64'h0, exp_err:0, exp_pulse:3};
        tbl[4] = '{iv:0, lv:1, ia:64'h0, la:64'h8000_0100, wen:1, wd:64'hDEAD_BEEF, wm:8'h0F, rdy:4, rsp:1,
                   rdata:64'h9999, exp_lsu:1, exp_data:64'h0, exp_err:0, exp_pulse:7};
        tbl[5] = '{iv:1, lv:0, ia:64'h8000_0008, la:64'h0, wen:0, wd:64'h0, wm:8'h0, rdy:0, rsp:-1,
                   rdata:64'h0, exp_lsu:0, exp_data:64'h0, exp_err:1, exp_pulse:10};
        tbl[6] = '{iv:1, lv:0, ia:64'h8000_000C, la:64'h0, wen:0, wd:64'h0, wm:8'h0, rdy:1, rsp:3,
                   rdata:64'hCAFE_F00D_1234_5678, exp_lsu:0, exp_data:64'hCAFE_F00D, exp_err:0, exp_pulse:6};
        tbl[7] = '{iv:0, lv:1, ia:64'h0, la:64'h3000, wen:0, wd:64'h0, wm:8'h0, rdy:0, rsp:8,
                   rdata:64'h0F0F_0F0F_F0F0_F0F0, exp_lsu:1, exp_data:64'h0F0F_0F0F_F0F0_F0F0, exp_err:0, exp_pulse:10};
        tbl[8] = '{iv:0, lv:1, ia:64'h0, la:64'h3008, wen:0, wd:64'h0, wm:8'h0, rdy:0, rsp:9,
                   rdata:64'h1234, exp_lsu:1, exp_data:64'h0, exp_err:1, exp_pulse:10};
        tbl[9] = '{iv:0, lv:1, ia:64'h0, la:64'h3010, wen:0, wd:64'h0, wm:8'h0, rdy:20, rsp:1,
                   rdata:64'h5678, exp_lsu:1, exp_data:64'h0, exp_err:1, exp_pulse:10};

        rst            = 1'b1;
        ifu_req_valid  = 1'b1;
        lsu_req_valid  = 1'b1;
        ifu_req_addr   = 64'h8000_0000;
        lsu_req_addr   = 64'h0;
        lsu_req_wen    = 1'b0;
        lsu_req_wdata  = 64'h0;
        lsu_req_wmask  = 8'h0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 64'h0;
        repeat (2) @(negedge clk);
        chk1("rst_ifu_ready", ifu_req_ready, 1'b0);
        chk1("rst_lsu_ready", lsu_req_ready, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_mem_req_valid", mem_req_valid, 1'b0);
        chk1("rst_ifu_resp_valid", ifu_resp_valid, 1'b0);
        chk1("rst_lsu_resp_valid", lsu_resp_valid, 1'b0);
        chk1("rst_bus_err", bus_err, 1'b0);
        chk64("rst_mem_req_addr", mem_req_addr, 64'h0);
        chk64("rst_lsu_resp_rdata", lsu_resp_rdata, 64'h0);
        chk64("rst_ifu_resp_inst", 64'(ifu_resp_inst), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycles(1);

        for (int i = 0; i < 10; i++) txn(tbl[i]);
        idle_cycles(2);

        for (int i = 0; i < 40; i++) begin
            r       = $urandom_range(1, 3);
            v.iv    = r[0];
            v.lv    = r[1];
            v.ia    = {$urandom, $urandom} & ~64'h3;
            v.la    = {$urandom, $urandom};
            v.wen   = 1'($urandom_range(0, 1));
            v.wd    = {$urandom, $urandom};
            v.wm    = 8'($urandom);
            v.rdy   = $urandom_range(0, 3);
            v.rsp   = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(1, 8);
            v.rdata = {$urandom, $urandom};
            v = model(v);
            txn(v);
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 2));
        end

        // Reset while waiting for the response: transaction vanishes, stale beat ignored.
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b0;
        ifu_req_addr  = 64'h8000_0020;
        #1;
        chk1("mid_rst_accept", ifu_req_ready, 1'b1);
        @(posedge clk);
        #1;
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk1("mid_rst_busy_wait", busy, 1'b1);
        @(posedge clk);
        #1;
        rst            = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'hFEED_FACE_0BAD_F00D;
        @(negedge clk);
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_mem_req_valid", mem_req_valid, 1'b0);
        chk1("mid_rst_ifu_resp", ifu_resp_valid, 1'b0);
        @(posedge clk);
        #1;
        mem_resp_valid = 1'b0;
        @(negedge clk);
        chk1("stale_ifu_resp", ifu_resp_valid, 1'b0);
        chk1("stale_lsu_resp", lsu_resp_valid, 1'b0);
        chk1("stale_bus_err", bus_err, 1'b0);
        chk1("stale_busy", busy, 1'b0);
`ifdef MEM_ARB_RR_EN
        m_last_lsu = 1'b0;
`endif
        txn(tbl[6]);
        idle_cycles(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
